// File: rtl/mprj_pad_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : mprj_pad_pkg                                                 |
// | Desc     : Shared state encoding and pad-safe constants for pad control |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package mprj_pad_pkg;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } pad_state_t;

  localparam logic PAD_OEN_SAFE = 1'b1;
  localparam logic PAD_REN_SAFE = 1'b0;

  function automatic int num_groups(input int n, input int g);
    return (n + g - 1) / g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mprj_pad_seq_ctrl_pad_in_sync.sv
// ---------------------------------------------------------------------------
// | Module   : pad_in_sync                                                  |
// | Desc     : Multi-bit, multi-stage async-reset input synchroniser        |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module pad_in_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/mprj_pad_seq_ctrl.sv
// ---------------------------------------------------------------------------
// | Module   : mprj_pad_seq_ctrl                                            |
// | Desc     : Pad ring sequencer: safe hold, pull apply, staggered OEN     |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module mprj_pad_seq_ctrl
  import mprj_pad_pkg::*;
#(
  parameter int                  NUM_PADS     = 38,
  parameter int                  GROUP_SIZE   = 4,
  parameter int                  SETTLE_CYC   = 16,
  parameter int                  STAGGER_CYC  = 8,
  parameter int                  SYNC_STAGES  = 2,
  parameter logic [NUM_PADS-1:0] DEFAULT_DIR  = {NUM_PADS{1'b0}},
  parameter logic [NUM_PADS-1:0] DEFAULT_PULL = {NUM_PADS{1'b1}}
) (
  input  logic                                         wb_clk_i,
  input  logic                                         wb_rst_i,
  input  logic                                         cfg_we,
  input  logic [((NUM_PADS > 1) ? $clog2(NUM_PADS) : 1)-1:0] cfg_idx,
  input  logic                                         cfg_dir,
  input  logic                                         cfg_pull,
  input  logic                                         cfg_reseq,
  input  logic [NUM_PADS-1:0]                          core_out,
  output logic [NUM_PADS-1:0]                          core_in,
  output logic [NUM_PADS-1:0]                          pad_out,
  input  logic [NUM_PADS-1:0]                          pad_in,
  output logic [NUM_PADS-1:0]                          pad_oen,
  output logic [NUM_PADS-1:0]                          pad_ren,
  output logic                                         ready
);

  localparam int NUM_GROUPS = num_groups(NUM_PADS, GROUP_SIZE);
  localparam int MAX_CYC    = (SETTLE_CYC > STAGGER_CYC) ? SETTLE_CYC : STAGGER_CYC;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);
  localparam int GRP_W      = $clog2(NUM_GROUPS + 1);

  pad_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [GRP_W-1:0]    r_grp;
  logic [NUM_PADS-1:0] r_pad_oen;
  logic [NUM_PADS-1:0] r_pad_ren;
  logic [NUM_PADS-1:0] r_pad_out;
  logic [NUM_PADS-1:0] r_cfg_dir;
  logic [NUM_PADS-1:0] r_cfg_pull;
  logic                r_ready;

  logic                w_wr_hit;
  logic [NUM_PADS-1:0] w_dir_nxt;
  logic [NUM_PADS-1:0] w_pull_nxt;
  logic [NUM_PADS-1:0] w_released;

  assign w_wr_hit = cfg_we && (int'(cfg_idx) < NUM_PADS);

  // Config as it will stand after this edge, so a release coinciding with a write sees it
  always_comb begin
    w_dir_nxt  = r_cfg_dir;
    w_pull_nxt = r_cfg_pull;
    if (w_wr_hit) begin
      w_dir_nxt[cfg_idx]  = cfg_dir;
      w_pull_nxt[cfg_idx] = cfg_pull;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_rel
      localparam int GRP_OF = gi / GROUP_SIZE;
      assign w_released[gi] = (r_state == RUN) ||
                              ((r_state == STAGGER) &&
                               ((GRP_OF < int'(r_grp)) ||
                                ((GRP_OF == int'(r_grp)) && (r_cnt != '0))));
    end
  endgenerate

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= SETTLE;
      r_cnt      <= '0;
      r_grp      <= '0;
      r_pad_oen  <= {NUM_PADS{PAD_OEN_SAFE}};
      r_pad_ren  <= {NUM_PADS{PAD_REN_SAFE}};
      r_pad_out  <= '0;
      r_ready    <= 1'b0;
      r_cfg_dir  <= DEFAULT_DIR;
      r_cfg_pull <= DEFAULT_PULL;
    end else begin
      r_pad_out  <= core_out;
      r_cfg_dir  <= w_dir_nxt;
      r_cfg_pull <= w_pull_nxt;
      if (cfg_reseq) begin
        r_state   <= SETTLE;
        r_cnt     <= '0;
        r_grp     <= '0;
        r_pad_oen <= {NUM_PADS{PAD_OEN_SAFE}};
        r_pad_ren <= {NUM_PADS{PAD_REN_SAFE}};
        r_ready   <= 1'b0;
      end else begin
        if (w_wr_hit && w_released[cfg_idx]) begin
          r_pad_oen[cfg_idx] <= ~cfg_dir;
          r_pad_ren[cfg_idx] <= ~cfg_pull;
        end
        case (r_state)
          SETTLE: begin
            if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
              r_pad_ren <= ~w_pull_nxt;
              r_state   <= STAGGER;
              r_cnt     <= '0;
              r_grp     <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          STAGGER: begin
            // grp == NUM_GROUPS marks the end of the last group's interval
            if (r_grp == GRP_W'(NUM_GROUPS)) begin
              r_state <= RUN;
              r_ready <= 1'b1;
              r_cnt   <= '0;
            end else begin
              if (r_cnt == '0) begin
                for (int i = 0; i < NUM_PADS; i++) begin
                  if ((i / GROUP_SIZE) == int'(r_grp)) begin
                    r_pad_oen[i] <= ~w_dir_nxt[i];
                    r_pad_ren[i] <= ~w_pull_nxt[i];
                  end
                end
              end
              if (r_cnt == CNT_W'(STAGGER_CYC - 1)) begin
                r_cnt <= '0;
                r_grp <= r_grp + 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          RUN: begin
          end
          default: r_state <= SETTLE;
        endcase
      end
    end
  end

  pad_in_sync #(
    .WIDTH  (NUM_PADS),
    .STAGES (SYNC_STAGES)
  ) u_pad_in_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .i_d (pad_in),
    .o_q (core_in)
  );

  assign pad_oen = r_pad_oen;
  assign pad_ren = r_pad_ren;
  assign pad_out = r_pad_out;
  assign ready   = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_mprj_pad_seq_ctrl.sv
// ---------------------------------------------------------------------------
// | Module   : tb_mprj_pad_seq_ctrl                                         |
// | Desc     : Scoreboard bench for the pad sequencer, cycle-keyed checks   |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mprj_pad_seq_ctrl;

  localparam int          N     = 38;
  localparam logic [N-1:0] ALL1 = {N{1'b1}};
  localparam logic [N-1:0] PULL = 38'h3F_FFFF_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we, cfg_dir, cfg_pull, cfg_reseq;
  logic [5:0]   cfg_idx;
  logic [N-1:0] core_out, core_in, pad_out, pad_in, pad_oen, pad_ren;
  logic         ready;

  int checks = 0;
  int failures = 0;
  int cyc;

  typedef struct {
    int           cyc;
    string        name;
    int           sel;
    logic [N-1:0] exp;
    logic [N-1:0] mask;
  } exp_t;

  exp_t q[$];

  mprj_pad_seq_ctrl #(
    .NUM_PADS     (N),
    .GROUP_SIZE   (4),
    .SETTLE_CYC   (16),
    .STAGGER_CYC  (8),
    .SYNC_STAGES  (2),
    .DEFAULT_DIR  (ALL1),
    .DEFAULT_PULL (PULL)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_dir   (cfg_dir),
    .cfg_pull  (cfg_pull),
    .cfg_reseq (cfg_reseq),
    .core_out  (core_out),
    .core_in   (core_in),
    .pad_out   (pad_out),
    .pad_in    (pad_in),
    .pad_oen   (pad_oen),
    .pad_ren   (pad_ren),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // Cycle index: edges since the last reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [N-1:0] bitv(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic void push(input int c, input string n, input int sel,
                               input logic [N-1:0] e, input logic [N-1:0] m);
    exp_t x;
    int   pos;
    x.cyc = c; x.name = n; x.sel = sel; x.exp = e; x.mask = m;
    pos = q.size();
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].cyc > c) begin
        pos = k;
        break;
      end
    end
    q.insert(pos, x);
  endfunction

  // Monitor: every falling edge, retire expectations that are due this cycle
  initial begin
    exp_t         e;
    logic [N-1:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        case (e.sel)
          0:       act = pad_oen;
          1:       act = pad_ren;
          2:       act = {{(N-1){1'b0}}, ready};
          3:       act = core_in;
          default: act = pad_out;
        endcase
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
        end else if ((act & e.mask) !== (e.exp & e.mask)) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%h required=%h", e.name, cyc,
                   act & e.mask, e.exp & e.mask);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cyc < n) begin
      failures++;
      $display("FAIL wait_cyc timeout actual=%0d required=%0d", cyc, n);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_dir = 1'b0; cfg_pull = 1'b0;
    cfg_reseq = 1'b0; core_out = '0; pad_in = '0;

    // Power-up sequence with all-output defaults and split pull defaults
    push(0,  "rst_oen",    0, ALL1, ALL1);
    push(0,  "rst_ren",    1, '0,   ALL1);
    push(0,  "rst_ready",  2, '0,   ALL1);
    push(15, "ren_c15",    1, '0,   ALL1);
    push(16, "ren_c16",    1, 38'h00_0000_FFFF, ALL1);
    push(16, "oen_c16",    0, ALL1, ALL1);
    push(17, "oen_c17",    0, 38'h3F_FFFF_FFF0, ALL1);
    push(24, "oen_c24",    0, 38'h3F_FFFF_FFF0, ALL1);
    push(25, "oen_c25",    0, 38'h3F_FFFF_FF00, ALL1);
    push(88, "oen_c88",    0, 38'h30_0000_0000, ALL1);
    push(89, "oen_c89",    0, '0,   ALL1);
    push(96, "ready_c96",  2, '0,   ALL1);
    push(97, "ready_c97",  2, 38'd1, ALL1);
    @(negedge clk);
    #1 rst = 1'b0;
    drain();

    // RUN-mode writes, out-of-range index, datapath latencies
    wait_cyc(100);
    push(100, "run_oen_pre", 0, '0, ALL1);
    push(101, "run_oen_w5",  0, bitv(5), ALL1);
    push(101, "run_ren_w5",  1, 38'h00_0000_FFDF, ALL1);
    cfg_we = 1'b1; cfg_idx = 6'd5; cfg_dir = 1'b0; cfg_pull = 1'b1;
    wait_cyc(101);
    push(102, "badidx_oen",  0, bitv(5), ALL1);
    push(102, "badidx_ren",  1, 38'h00_0000_FFDF, ALL1);
    cfg_idx = 6'd40; cfg_dir = 1'b0; cfg_pull = 1'b0;
    wait_cyc(102);
    cfg_we = 1'b0;
    core_out[9] = 1'b1;
    pad_in[7] = 1'b1;
    push(102, "pad_out9_pre", 4, '0, bitv(9));
    push(103, "pad_out9",     4, bitv(9), bitv(9));
    push(103, "core_in7_e1",  3, '0, bitv(7));
    push(104, "core_in7_e2",  3, bitv(7), bitv(7));
    drain();

    // Fresh reset, then writes during STAGGER
    rst = 1'b1;
    core_out = '0; pad_in = '0;
    @(negedge clk);
    #1 rst = 1'b0;
    push(20, "stg_oen20",  0, 38'h3F_FFFF_FFF0, ALL1);
    push(21, "stg_oen21",  0, 38'h3F_FFFF_FFF2, ALL1);
    push(22, "stg_ren22",  1, 38'h00_0000_FFFF, ALL1);
    push(25, "stg_oen25",  0, 38'h3F_FFFF_FF02, ALL1);
    push(72, "stg_oen72",  0, 38'h3F_F000_0002, ALL1);
    push(73, "stg_oen73",  0, 38'h3F_4000_0002, ALL1);
    wait_cyc(20);
    cfg_we = 1'b1; cfg_idx = 6'd1; cfg_dir = 1'b0; cfg_pull = 1'b0;
    wait_cyc(21);
    cfg_idx = 6'd30; cfg_dir = 1'b0; cfg_pull = 1'b1;
    wait_cyc(22);
    cfg_we = 1'b0;
    drain();

    // Asynchronous reset between edges while mid-STAGGER
    wait_cyc(75);
    rst = 1'b1;
    #1;
    push(0, "arst_oen",   0, ALL1, ALL1);
    push(0, "arst_ren",   1, '0,   ALL1);
    push(0, "arst_ready", 2, '0,   ALL1);
    @(negedge clk);
    #1 rst = 1'b0;
    push(16, "re_ren16",   1, 38'h00_0000_FFFF, ALL1);
    push(17, "re_oen17",   0, 38'h3F_FFFF_FFF0, ALL1);
    push(73, "re_oen73",   0, 38'h3F_0000_0000, ALL1);
    push(96, "re_ready96", 2, '0, ALL1);
    push(97, "re_ready97", 2, 38'd1, ALL1);
    drain();

    // Reseq in RUN with a simultaneous write to pad 2
    wait_cyc(100);
    push(100,      "pre_reseq_oen", 0, '0, ALL1);
    push(101,      "reseq_oen",     0, ALL1, ALL1);
    push(101,      "reseq_ren",     1, '0, ALL1);
    push(101,      "reseq_ready",   2, '0, ALL1);
    push(101 + 15, "reseq_ren15",   1, '0, ALL1);
    push(101 + 16, "reseq_ren16",   1, 38'h00_0000_FFFB, ALL1);
    push(101 + 17, "reseq_oen17",   0, 38'h3F_FFFF_FFF4, ALL1);
    push(101 + 96, "reseq_rdy96",   2, '0, ALL1);
    push(101 + 97, "reseq_rdy97",   2, 38'd1, ALL1);
    push(101 + 97, "reseq_oen97",   0, bitv(2), ALL1);
    cfg_reseq = 1'b1; cfg_we = 1'b1; cfg_idx = 6'd2; cfg_dir = 1'b0; cfg_pull = 1'b1;
    wait_cyc(101);
    cfg_reseq = 1'b0; cfg_we = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
